// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel push-button synchroniser, debouncer, long-press and auto-repeat
module debounce_multi #(
  parameter int N_BTN           = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 24000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_CYCLES   = 4800000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  // Raw pin level that means "not pressed"; the synchroniser resets to it
  localparam logic          RAW_IDLE  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_HELD,
    ST_REPEAT,
    ST_LATCHED
  } state_t;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          sync_p;
    logic          level;
    logic          press_p;
    logic          rel_p;
    logic          long_p;
    logic          repeat_p;
    logic          flip;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    state_t        state;

    // Pressed = 1 regardless of pin polarity
    assign sync_p = (ACTIVE_LOW != 0) ? ~s2 : s2;
    // Level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES clocks
    assign flip   = (sync_p != level) && (cnt == DB_LAST);
    assign rise   = flip & sync_p;
    assign fall   = flip & ~sync_p;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1 <= RAW_IDLE;
        s2 <= RAW_IDLE;
      end else begin
        s1 <= i_btn[g];
        s2 <= s1;
      end
    end

    // Stable-time counter; press/release pulses coincide with the first cycle of the new level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt     <= '0;
        level   <= 1'b0;
        press_p <= 1'b0;
        rel_p   <= 1'b0;
      end else begin
        press_p <= rise;
        rel_p   <= fall;
        if (sync_p == level) begin
          cnt <= '0;
        end else if (flip) begin
          level <= sync_p;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // Hold FSM: long-press then optional auto-repeat; a release wins over a same-cycle pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state    <= ST_RELEASED;
        hcnt     <= '0;
        long_p   <= 1'b0;
        repeat_p <= 1'b0;
      end else begin
        long_p   <= 1'b0;
        repeat_p <= 1'b0;
        if (fall) begin
          state <= ST_RELEASED;
          hcnt  <= '0;
        end else begin
          case (state)
            ST_RELEASED: begin
              hcnt <= '0;
              if (rise) state <= ST_HELD;
            end
            ST_HELD: begin
              if (hcnt == LONG_LAST) begin
                long_p <= 1'b1;
                hcnt   <= '0;
                if (REPEAT_EN != 0) state <= ST_REPEAT;
                else                state <= ST_LATCHED;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            ST_REPEAT: begin
              if (hcnt == REP_LAST) begin
                repeat_p <= 1'b1;
                hcnt     <= '0;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            ST_LATCHED: begin
              hcnt <= '0;
            end
            default: begin
              state <= ST_RELEASED;
              hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign o_level[g]   = level;
    assign o_press[g]   = press_p;
    assign o_release[g] = rel_p;
    assign o_long[g]    = long_p;
    assign o_repeat[g]  = repeat_p;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi across three parameter sets
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn0, btn1, btn2;
  logic [3:0] lvl[3], prs[3], rel[3], lng[3], rpt[3];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int d;
    int kind;
    int ch;
    int at;
  } ev_t;

  ev_t   exp_q[$];
  string kname[4] = '{"press", "release", "long", "repeat"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: main configuration
  debounce_multi #(.N_BTN(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(40),
                   .REPEAT_EN(1), .REPEAT_CYCLES(10)) u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn0), .o_level(lvl[0]), .o_press(prs[0]),
    .o_release(rel[0]), .o_long(lng[0]), .o_repeat(rpt[0]));

  // dut 1: auto-repeat disabled
  debounce_multi #(.N_BTN(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(40),
                   .REPEAT_EN(0), .REPEAT_CYCLES(10)) u_norep (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn1), .o_level(lvl[1]), .o_press(prs[1]),
    .o_release(rel[1]), .o_long(lng[1]), .o_repeat(rpt[1]));

  // dut 2: active-high buttons
  debounce_multi #(.N_BTN(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(40),
                   .REPEAT_EN(1), .REPEAT_CYCLES(10)) u_ahigh (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn2), .o_level(lvl[2]), .o_press(prs[2]),
    .o_release(rel[2]), .o_long(lng[2]), .o_repeat(rpt[2]));

  function automatic logic [3:0] pulses(int d, int k);
    case (k)
      0:       return prs[d];
      1:       return rel[d];
      2:       return lng[d];
      default: return rpt[d];
    endcase
  endfunction

  task automatic expect_ev(input int d, input int kind, input int ch, input int at);
    ev_t e;
    e.d = d; e.kind = kind; e.ch = ch; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input string nm, input int d);
    chk({nm, "_level"},   lvl[d], 4'b0000);
    chk({nm, "_press"},   prs[d], 4'b0000);
    chk({nm, "_release"}, rel[d], 4'b0000);
    chk({nm, "_long"},    lng[d], 4'b0000);
    chk({nm, "_repeat"},  rpt[d], 4'b0000);
  endtask

  // Monitor: every output pulse must match a queued expectation at the expected cycle
  always @(negedge clk) begin
    logic [3:0] p;
    int idx;
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 4; k++) begin
          p = pulses(d, k);
          for (int ch = 0; ch < 4; ch++) begin
            if (p[ch]) begin
              idx = -1;
              for (int i = 0; i < exp_q.size(); i++)
                if (idx < 0 && exp_q[i].d == d && exp_q[i].kind == k && exp_q[i].ch == ch) idx = i;
              total++;
              if (idx < 0) begin
                bad++;
                $display("FAIL %s dut%0d ch%0d: unexpected pulse at cycle %0d, required none", kname[k], d, ch, cyc);
              end else begin
                if (exp_q[idx].at != cyc) begin
                  bad++;
                  $display("FAIL %s dut%0d ch%0d: pulse at cycle %0d, required at cycle %0d", kname[k], d, ch, cyc, exp_q[idx].at);
                end
                exp_q.delete(idx);
              end
              if (k < 2) begin
                total++;
                if (lvl[d][ch] !== (k == 0)) begin
                  bad++;
                  $display("FAIL level_with_%s dut%0d ch%0d: level %b, required %0d", kname[k], d, ch, lvl[d][ch], (k == 0));
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    btn0  = 4'hF;
    btn1  = 4'hF;
    btn2  = 4'h0;

    at_cyc(2);
    for (int d = 0; d < 3; d++) chk_zero("reset", d);
    at_cyc(3);
    rst_n = 1'b1;

    // Clean press on all three duts, channel 0
    at_cyc(10);
    btn0[0] = 1'b0;
    expect_ev(0, 0, 0, 20);
    expect_ev(0, 2, 0, 60);
    for (int r = 1; r <= 5; r++) expect_ev(0, 3, 0, 60 + 10 * r);
    btn1[0] = 1'b0;
    expect_ev(1, 0, 0, 20);
    expect_ev(1, 2, 0, 60);
    btn2[0] = 1'b1;
    expect_ev(2, 0, 0, 20);

    // 7-cycle glitch: filtered out
    at_cyc(20);
    btn0[2] = 1'b0;
    at_cyc(27);
    btn0[2] = 1'b1;

    // Active-high channel released before long press
    at_cyc(30);
    btn2[0] = 1'b0;
    expect_ev(2, 1, 0, 40);

    // Bounce: toggle every 3 cycles, then settle pressed
    for (int k = 0; k < 10; k++) begin
      at_cyc(40 + 3 * k);
      btn0[1] = (k % 2 == 1);
    end
    at_cyc(70);
    btn0[1] = 1'b0;
    expect_ev(0, 0, 1, 80);
    at_cyc(90);
    btn0[1] = 1'b1;
    expect_ev(0, 1, 1, 100);

    // Release lands on the same edge as a due repeat: repeat suppressed
    at_cyc(110);
    btn0[0] = 1'b1;
    expect_ev(0, 1, 0, 120);

    // Exactly DEBOUNCE_CYCLES-long press: accepted
    at_cyc(130);
    btn0[2] = 1'b0;
    expect_ev(0, 0, 2, 140);
    at_cyc(138);
    btn0[2] = 1'b1;
    expect_ev(0, 1, 2, 148);

    // Release 20 cycles after press: no long
    at_cyc(160);
    btn0[3] = 1'b0;
    expect_ev(0, 0, 3, 170);
    at_cyc(190);
    btn0[3] = 1'b1;
    expect_ev(0, 1, 3, 200);

    // Repeat-disabled dut held 200 cycles
    at_cyc(210);
    btn1[0] = 1'b1;
    expect_ev(1, 1, 0, 220);

    // Simultaneous channels, then reset mid-hold
    at_cyc(220);
    btn0[0] = 1'b0;
    btn0[3] = 1'b0;
    expect_ev(0, 0, 0, 230);
    expect_ev(0, 0, 3, 230);
    at_cyc(240);
    chk("level_both", lvl[0], 4'b1001);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset", 0);
    at_cyc(245);
    rst_n = 1'b1;
    expect_ev(0, 0, 0, 255);
    expect_ev(0, 0, 3, 255);
    at_cyc(265);
    btn0[0] = 1'b1;
    btn0[3] = 1'b1;
    expect_ev(0, 1, 0, 275);
    expect_ev(0, 1, 3, 275);

    at_cyc(310);
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s dut%0d ch%0d: no pulse seen, required at cycle %0d",
               kname[exp_q[0].kind], exp_q[0].d, exp_q[0].ch, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
